// File: rtl/coeff_stream_loader_if.sv
// coeff_stream_loader_if
// Bundles the byte-stream handshake and the coefficient-write / status outputs of
// coeff_stream_loader.
//   s_data/s_valid/s_ready           : framed byte stream, valid/ready handshake
//   coeff_write_enable/addr/data     : single-cycle coefficient write into the FIR filter
//   busy/filter_hold                 : frame in progress (filter input is paused)
//   done/err                         : good-frame pulse / sticky error flag
// master: the stream source and status consumer. slave: the loader.
interface coeff_stream_loader_if;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;
   logic       coeff_write_enable;
   logic [6:0] coeff_addr;
   logic [7:0] coeff_data;
   logic       busy;
   logic       filter_hold;
   logic       done;
   logic       err;

   modport master (
      output s_data,
      output s_valid,
      input  s_ready,
      input  coeff_write_enable,
      input  coeff_addr,
      input  coeff_data,
      input  busy,
      input  filter_hold,
      input  done,
      input  err
   );

   modport slave (
      input  s_data,
      input  s_valid,
      output s_ready,
      output coeff_write_enable,
      output coeff_addr,
      output coeff_data,
      output busy,
      output filter_hold,
      output done,
      output err
   );
endinterface

// File: rtl/coeff_stream_loader.sv
// coeff_stream_loader
// Parses a framed byte stream (SYNC, ADDR, COUNT, COUNT data bytes, CSUM), issues one
// registered coefficient write per data byte and reports the frame outcome.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : coeff_stream_loader_if.slave (stream in, coefficient writes and status out)
// Parameters:
//   TIMEOUT_CYCLES : idle cycles tolerated between bytes inside a frame
//   SYNC_BYTE      : frame start marker
module coeff_stream_loader #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
   input  logic                        clk,
   input  logic                        rst_n,
   coeff_stream_loader_if.slave        bus
);

   localparam int unsigned     TmoW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]      CountMax = 8'd128;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StCount,
      StData,
      StCsum,
      StDone
   } state_e;

   state_e          state_q, state_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic [6:0]      ptr_q, ptr_d;    // address of the next coefficient write
   logic [7:0]      rem_q, rem_d;    // coefficient bytes still expected
   logic [7:0]      sum_q, sum_d;    // running checksum over ADDR, COUNT and data
   logic            we_q, we_d;
   logic [6:0]      addr_q, addr_d;
   logic [7:0]      data_q, data_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   logic ready;
   logic xfer;
   logic in_frame;
   logic timeout;

   // Ready is decoded from the state register; gating with rst_n keeps it low during reset.
   assign ready    = rst_n && (state_q != StDone);
   assign xfer     = bus.s_valid && ready;
   assign in_frame = (state_q == StAddr) || (state_q == StCount) ||
                     (state_q == StData) || (state_q == StCsum);
   assign timeout  = in_frame && !xfer && (tmo_q == TmoLast);

   always_comb begin
      state_d = state_q;
      tmo_d   = '0;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      sum_d   = sum_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = err_q;

      if (in_frame && !xfer) begin
         tmo_d = tmo_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (xfer && (bus.s_data == SYNC_BYTE)) begin
               err_d   = 1'b0;
               state_d = StAddr;
            end
         end
         StAddr: begin
            if (xfer) begin
               if (bus.s_data[7]) begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end else begin
                  ptr_d   = bus.s_data[6:0];
                  sum_d   = bus.s_data;
                  state_d = StCount;
               end
            end
         end
         StCount: begin
            if (xfer) begin
               if ((bus.s_data == 8'd0) || (bus.s_data > CountMax)) begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end else begin
                  rem_d   = bus.s_data;
                  sum_d   = sum_q + bus.s_data;
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (xfer) begin
               we_d   = 1'b1;
               addr_d = ptr_q;
               data_d = bus.s_data;
               ptr_d  = ptr_q + 7'd1;   // wraps 7F -> 00
               sum_d  = sum_q + bus.s_data;
               rem_d  = rem_q - 8'd1;
               if (rem_q == 8'd1) begin
                  state_d = StCsum;
               end
            end
         end
         StCsum: begin
            if (xfer) begin
               state_d = StDone;
               if (bus.s_data == sum_q) begin
                  done_d = 1'b1;
               end else begin
                  err_d  = 1'b1;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (timeout) begin
         err_d   = 1'b1;
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         tmo_q   <= '0;
         ptr_q   <= '0;
         rem_q   <= '0;
         sum_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         sum_q   <= sum_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign bus.s_ready            = ready;
   assign bus.coeff_write_enable = we_q;
   assign bus.coeff_addr         = addr_q;
   assign bus.coeff_data         = data_q;
   assign bus.busy               = (state_q != StIdle);
   assign bus.filter_hold        = (state_q != StIdle);
   assign bus.done               = done_q;
   assign bus.err                = err_q;

endmodule

// File: doc/coeff_stream_loader.md
# coeff_stream_loader

Upstream feeder for the FIR filter's coefficient port. It accepts a framed byte stream over a valid/ready handshake, checks it, and issues single-cycle coefficient writes (enable, 7-bit address, 8-bit data) into the filter. It also asserts a hold output so sample input to the filter is paused while a coefficient set is being loaded.

## Interface
- TIMEOUT_CYCLES, 1024: number of idle cycles allowed between accepted bytes inside a frame before the frame is aborted.
- SYNC_BYTE, 8'hA5: frame start marker.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
- s_data  input  8  stream byte.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  loader accepts s_data this cycle.
- coeff_write_enable  output  1  one-cycle write strobe to the filter.
- coeff_addr  output  7  coefficient address.
- coeff_data  output  8  coefficient value.
- busy  output  1  frame in progress.
- filter_hold  output  1  equals busy; the filter's data_valid is gated with it.
- done  output  1  one-cycle pulse on a good frame.
- err  output  1  sticky error flag.

## Operation
- Frame format: SYNC, ADDR (bit7 = 0), COUNT (1..128), COUNT coefficient bytes, CSUM.
- CSUM = (ADDR + COUNT + sum of coefficients) mod 256.
- A byte transfers on a rising edge with s_valid && s_ready.
- States: IDLE, ADDR, COUNT, DATA, CSUM, DONE.
- IDLE: discard bytes until SYNC_BYTE arrives, then go to ADDR. Accepting SYNC clears err.
- ADDR: if bit7 = 1, set err and go to IDLE. Otherwise latch the start address and go to COUNT.
- COUNT: if the value is 0 or greater than 128, set err and go to IDLE. Otherwise latch the remaining count and go to DATA.
- DATA: for each accepted byte, issue one write with address = start + index (mod 128, wraps 7F→00), accumulate the checksum, and decrement the remaining count. Go to CSUM after the last byte.
- CSUM: on a match, pulse done. On a mismatch, set err with no done pulse. Either way go to DONE.
  - Writes already issued are not undone.
- DONE: lasts one cycle with s_ready = 0, then IDLE.
- Timeout: in ADDR, COUNT, DATA or CSUM, a counter increments each cycle without a transfer and clears on every transfer. On reaching TIMEOUT_CYCLES: set err, go to IDLE, no further writes.
- busy/filter_hold = 1 in ADDR, COUNT, DATA, CSUM and DONE; 0 in IDLE.
- s_ready = 1 in every state except DONE; 0 while rst_n is low.

## Timing
- Reset values: s_ready 0 during reset, 1 after release. All other outputs 0: coeff_write_enable, coeff_addr, coeff_data, busy, filter_hold, done, err.
- Write latency: a coefficient byte accepted at edge N produces coeff_write_enable = 1 with stable addr/data during cycle N+1. All write outputs are registered.
- Back-to-back coefficient bytes give back-to-back write strobes, one per cycle.
- coeff_addr and coeff_data hold their last values when the strobe is low.
- CSUM accepted at edge N: done (or err) is asserted in cycle N+1 (DONE state). busy drops in cycle N+2.
- A SYNC byte offered during DONE is not accepted (s_ready = 0); it is taken in the following IDLE cycle.
- The last coefficient write and the DONE cycle never overlap: the write happens at CSUM time or earlier.
- err stays high from the cycle after the error until the next accepted SYNC; it then reads 0 from the following cycle.
- Reset mid-frame: all state clears at once and any pending write is dropped. No write strobe is emitted after the reset assertion.

## Test plan
- Good frame A5,00,02,05,0A,11 streamed back-to-back → writes (0,0x05) then (1,0x0A) on consecutive cycles; done pulses once; err = 0; busy low two cycles after CSUM.
- Same frame with CSUM 0x12 → both writes occur; no done pulse; err = 1 until the next A5 is accepted.
- Wrap frame A5,7F,02,03,04,88 → writes (0x7F,0x03) then (0x00,0x04); done pulses.
- Leading garbage 00,FF,3C, then a good frame → no writes or busy before A5; frame completes normally. Also: COUNT = 0 and ADDR = 0x80 → err = 1, no writes, return to IDLE.
- TIMEOUT_CYCLES = 16: send A5,10, then hold s_valid low → err set 16 cycles after the last transfer; busy/filter_hold drop; a later good frame loads correctly.
- rst_n pulled low in the middle of DATA with s_valid still high → all outputs 0 immediately; no write after reset; after release a new good frame works.
